fifo_wr_arb_ctrl: RTL and testbench
===================================

# fifo_wr_arb_ctrl

Single-clock controller that sequences the `fifo_mem` storage array. It arbitrates two producer ports onto the memory's single write port using round-robin arbitration, and it owns the write and read pointers. It also generates the full, empty, almost-full and count status. The consumer reads data straight from the memory's asynchronous read output, addressed by `mem_r_addr`.

## Interface
- `DATA_WIDTH`, 8, width of each data word
- `ADDR_SIZE`, 3, memory address width; depth is fixed at 2**ADDR_SIZE
- `AF_LEVEL`, 6, almost-full threshold in entries, legal range 1..2**ADDR_SIZE

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `wr0_valid`  in  1  producer 0 has a word
- `wr0_data`  in  DATA_WIDTH  producer 0 word
- `wr0_ready`  out  1  producer 0 word accepted this cycle when `wr0_valid` is also high
- `wr1_valid`, `wr1_data`, `wr1_ready`: same as the producer 0 ports, for producer 1
- `rd_valid`  out  1  memory output at `mem_r_addr` holds valid data
- `rd_ready`  in  1  consumer pops the word this cycle
- `mem_data`  out  DATA_WIDTH  write data to the memory
- `mem_w_addr`  out  ADDR_SIZE  write address
- `mem_r_addr`  out  ADDR_SIZE  read address
- `mem_w_en`  out  1  memory write enable
- `full`  out  1  2**ADDR_SIZE entries stored
- `empty`  out  1  0 entries stored
- `almost_full`  out  1  count >= AF_LEVEL
- `count`  out  ADDR_SIZE+1  current occupancy, 0..2**ADDR_SIZE

## Operation
- **Pointers.** `wptr` and `rptr` are each ADDR_SIZE+1 bits wide and wrap modulo 2**(ADDR_SIZE+1).
  - `mem_w_addr` = `wptr[ADDR_SIZE-1:0]`; `mem_r_addr` = `rptr[ADDR_SIZE-1:0]`.
  - `count` = `wptr - rptr`, computed modulo 2**(ADDR_SIZE+1).
  - `full` when the pointer MSBs differ and the low bits are equal.
  - `empty` when `wptr == rptr`.
- **Arbitration.** A one-bit round-robin priority register `prio` sets the grant when both producers request.
  - When `full`, no grant is given: both `wrN_ready` = 0.
  - When not full and both valids are high, the grant goes to producer `prio`.
  - When not full and exactly one valid is high, the grant goes to that producer.
  - When neither valid is high, no grant is given.
  - `wrN_ready` = not full AND grant to N. Ready depends combinationally on valid; producers must not make valid depend on ready.
  - After each accepted write, `prio` becomes the non-granted producer. `prio` holds when no write is accepted.
- **Write.**
  - `mem_w_en` = `(wr0_valid & wr0_ready) | (wr1_valid & wr1_ready)`.
  - `mem_data` = data of the granted producer. When there is no grant, it is `wr0_data`.
  - On an accepted write, `wptr` increments.
- **Read.**
  - `rd_valid` = not `empty`.
  - A pop happens when `rd_valid & rd_ready`; `rptr` increments.
  - `rd_ready` while empty is ignored.
- **Simultaneous push and pop.** Both pointers advance and `count` is unchanged.
  - When full, the write is still refused in the same cycle as a pop; it succeeds next cycle.
  - When empty, a same-cycle write is not visible to the reader that cycle.
- **Reset.** Asserting `rst` at any time, including mid-transfer, has these effects:
  - `wptr`, `rptr` and `prio` are cleared to 0.
  - Memory contents are not cleared; stale data is unreachable because the FIFO is empty.
  - Output values during and after reset: `empty`=1, `full`=0, `almost_full`=0, `count`=0, `rd_valid`=0, `mem_w_en`=0.
  - During reset, `wrN_ready` = 1 if the producer is granted; these writes are discarded.
  - Deasserting reset is synchronised externally to `clk`.

## Timing
- **Write-to-read latency.** A word accepted at edge k (memory written and `wptr` advanced at that edge) is visible as `rd_valid`=1 on the `mem_r_addr` output in the cycle after edge k.
- **Pop.** `rptr` advances at the popping edge. The next word appears combinationally through the memory's asynchronous read in the following cycle.
- **Status outputs.** `full`, `empty`, `almost_full` and `count` derive only from registered pointers, with no combinational path from valid or ready.
- **Throughput.** One write and one read per cycle sustained.
- **Depth.** Stores 2**ADDR_SIZE entries; no entry is lost to full/empty disambiguation.

## Test plan
- **Reset values.** Assert `rst` mid-cycle with `wr0_valid`=1 → immediately `empty`=1, `count`=0, `rd_valid`=0, `mem_w_en`=0. After release with no valids, all status is unchanged.
- **Fill and drain.** Producer 0 alone writes 0x10..0x17 with `rd_ready`=0.
  - Expect `count` 1..8, `almost_full` rising when `count` reaches 6, `full`=1 at 8, and `wr0_ready`=0 at 8.
  - Then pop 8 words and check data 0x10..0x17 in order, ending `empty`=1.
- **Round-robin.** Both producers valid continuously, producer 0 sending 0xA0+, producer 1 sending 0xB0+.
  - Accept order is A0,B0,A1,B1,…
  - After producer 0 idles for one cycle, a single producer 1 write sets `prio`=0.
- **Pointer wrap.** Stream 20 words with concurrent pops while holding `count` at 2–3. Data stays in order across two wraps of the address space.
- **Full with pop.** At `full`, assert both `wr0_valid` and `rd_ready`. In that cycle `wr0_ready`=0 and `count` becomes 7. Next cycle the write is accepted and `count` returns to 8.
- **Reset mid-stream.** With `count`=5, assert `rst` → `count`=0 and `empty`=1. A new write of 0x55 then reads back as 0x55, not stale data.

Source files
------------

// File: rtl/fifo_wr_arb_ctrl_if.sv
// Handshake and memory-control bundle between two producers, one consumer,
// the FIFO controller and the fifo_mem storage array.
interface fifo_wr_arb_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE  = 3
);
    logic                  wr0_valid;
    logic [DATA_WIDTH-1:0] wr0_data;
    logic                  wr0_ready;
    logic                  wr1_valid;
    logic [DATA_WIDTH-1:0] wr1_data;
    logic                  wr1_ready;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [ADDR_SIZE-1:0]  mem_w_addr;
    logic [ADDR_SIZE-1:0]  mem_r_addr;
    logic                  mem_w_en;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic [ADDR_SIZE:0]    count;

    modport master (
        output wr0_valid, wr0_data, wr1_valid, wr1_data, rd_ready,
        input  wr0_ready, wr1_ready, rd_valid, mem_data, mem_w_addr,
               mem_r_addr, mem_w_en, full, empty, almost_full, count
    );

    modport slave (
        input  wr0_valid, wr0_data, wr1_valid, wr1_data, rd_ready,
        output wr0_ready, wr1_ready, rd_valid, mem_data, mem_w_addr,
               mem_r_addr, mem_w_en, full, empty, almost_full, count
    );
endinterface

// File: rtl/fifo_wr_arb_ctrl.sv
// FIFO controller: round-robin arbitration of two producers onto the single
// memory write port, read/write pointer ownership and occupancy status.
module fifo_wr_arb_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE  = 3,
    parameter int AF_LEVEL   = 6
) (
    input logic              clk,
    input logic              rst,
    fifo_wr_arb_ctrl_if.slave bus
);
    typedef logic [ADDR_SIZE:0] ptr_t;

    localparam ptr_t AF_THR = ptr_t'(AF_LEVEL);
    localparam ptr_t PTR_ONE = ptr_t'(1);

    ptr_t                  wptr;
    ptr_t                  rptr;
    ptr_t                  occupancy;
    logic                  prio;
    logic                  full_i;
    logic                  empty_i;
    logic                  gnt0;
    logic                  gnt1;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] wr_data_sel;

    always_comb begin
        occupancy = wptr - rptr;
        empty_i   = (wptr == rptr);
        full_i    = (wptr[ADDR_SIZE] != rptr[ADDR_SIZE]) &&
                    (wptr[ADDR_SIZE-1:0] == rptr[ADDR_SIZE-1:0]);
        gnt0      = !full_i && bus.wr0_valid && (!bus.wr1_valid || !prio);
        gnt1      = !full_i && bus.wr1_valid && (!bus.wr0_valid || prio);
        // Grants stay visible during reset, but nothing is committed.
        push      = !rst && (gnt0 || gnt1);
        pop       = !empty_i && bus.rd_ready;
        wr_data_sel = gnt1 ? bus.wr1_data : bus.wr0_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            prio <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_ONE;
                // Next priority goes to whichever producer was not granted.
                prio <= gnt0;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    assign bus.wr0_ready   = gnt0;
    assign bus.wr1_ready   = gnt1;
    assign bus.mem_w_en    = push;
    assign bus.mem_data    = wr_data_sel;
    assign bus.mem_w_addr  = wptr[ADDR_SIZE-1:0];
    assign bus.mem_r_addr  = rptr[ADDR_SIZE-1:0];
    assign bus.rd_valid    = !empty_i;
    assign bus.full        = full_i;
    assign bus.empty       = empty_i;
    assign bus.count       = occupancy;
    assign bus.almost_full = (occupancy >= AF_THR);
endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// Directed self-checking bench for fifo_wr_arb_ctrl with a behavioural
// async-read memory standing in for fifo_mem.
module tb_fifo_wr_arb_ctrl;
    localparam int DW = 8;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_wr_arb_ctrl_if #(.DATA_WIDTH(DW), .ADDR_SIZE(AW)) bus ();

    fifo_wr_arb_ctrl #(.DATA_WIDTH(DW), .ADDR_SIZE(AW), .AF_LEVEL(6)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [DW-1:0] mem [8];
    logic [DW-1:0] rd_data;
    always @(posedge clk) if (bus.mem_w_en) mem[bus.mem_w_addr] <= bus.mem_data;
    assign rd_data = mem[bus.mem_r_addr];

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] rr_exp [7];
    int a_i, b_i, n_wr, n_rd;

    initial begin
        rr_exp = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hA3};
        bus.wr0_valid = 1'b0; bus.wr0_data = '0;
        bus.wr1_valid = 1'b0; bus.wr1_data = '0;
        bus.rd_ready  = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("init_empty", bus.empty, 1);
        chk("init_count", bus.count, 0);

        // Reset asserted mid-cycle while producer 0 is active
        bus.wr0_valid = 1'b1; bus.wr0_data = 8'h01;
        tick(); tick();
        chk("pre_rst_count", bus.count, 2);
        #2 rst = 1'b1;
        #1;
        chk("rst_empty", bus.empty, 1);
        chk("rst_count", bus.count, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_mem_w_en", bus.mem_w_en, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_af", bus.almost_full, 0);
        chk("rst_wr0_ready", bus.wr0_ready, 1);
        tick();
        chk("rst_discard", bus.count, 0);
        rst = 1'b0;
        bus.wr0_valid = 1'b0;
        tick();
        chk("post_rst_empty", bus.empty, 1);
        chk("post_rst_count", bus.count, 0);
        chk("post_rst_rd_valid", bus.rd_valid, 0);

        // Fill and drain with producer 0 alone
        for (int i = 0; i < 8; i++) begin
            bus.wr0_valid = 1'b1;
            bus.wr0_data  = 8'(8'h10 + i);
            #1;
            chk("fill_ready", bus.wr0_ready, 1);
            tick();
            chk("fill_count", bus.count, 32'(i + 1));
            chk("fill_af", bus.almost_full, (i + 1 >= 6));
            chk("fill_full", bus.full, (i + 1 == 8));
        end
        bus.wr0_data = 8'h18;
        #1;
        chk("full_ready", bus.wr0_ready, 0);
        chk("full_w_en", bus.mem_w_en, 0);
        tick();
        chk("full_hold", bus.count, 8);
        bus.wr0_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.rd_ready = 1'b1;
            #1;
            chk("drain_valid", bus.rd_valid, 1);
            chk("drain_data", rd_data, 32'(8'h10 + i));
            tick();
        end
        bus.rd_ready = 1'b0;
        chk("drain_empty", bus.empty, 1);
        chk("drain_count", bus.count, 0);

        rst = 1'b1; tick(); rst = 1'b0; tick();

        // Round-robin with both producers requesting
        a_i = 0; b_i = 0;
        for (int k = 0; k < 5; k++) begin
            bus.wr0_valid = 1'b1; bus.wr0_data = 8'(8'hA0 + a_i);
            bus.wr1_valid = 1'b1; bus.wr1_data = 8'(8'hB0 + b_i);
            #1;
            chk("rr_ready0", bus.wr0_ready, (k % 2 == 0));
            chk("rr_ready1", bus.wr1_ready, (k % 2 == 1));
            chk("rr_data", bus.mem_data, 32'(rr_exp[k]));
            tick();
            if (k % 2 == 0) a_i++; else b_i++;
        end
        bus.wr0_valid = 1'b0; bus.wr1_data = 8'(8'hB0 + b_i);
        #1;
        chk("rr_solo_ready1", bus.wr1_ready, 1);
        chk("rr_solo_data", bus.mem_data, 32'h B2);
        tick();
        bus.wr0_valid = 1'b1; bus.wr0_data = 8'(8'hA0 + a_i);
        bus.wr1_data  = 8'hB3;
        #1;
        chk("rr_prio0_ready0", bus.wr0_ready, 1);
        chk("rr_prio0_ready1", bus.wr1_ready, 0);
        chk("rr_prio0_data", bus.mem_data, 32'h A3);
        tick();
        bus.wr0_valid = 1'b0; bus.wr1_valid = 1'b0;
        chk("rr_count", bus.count, 7);
        for (int i = 0; i < 7; i++) begin
            bus.rd_ready = 1'b1;
            #1;
            chk("rr_order", rd_data, 32'(rr_exp[i]));
            tick();
        end
        bus.rd_ready = 1'b0;
        chk("rr_empty", bus.empty, 1);

        // Streaming across two pointer wraps
        n_wr = 0; n_rd = 0;
        for (int cyc = 0; cyc < 22; cyc++) begin
            bus.wr0_valid = (n_wr < 20);
            bus.wr0_data  = 8'(8'h30 + n_wr);
            bus.rd_ready  = (cyc >= 2);
            #1;
            if (cyc >= 2) begin
                chk("wrap_valid", bus.rd_valid, 1);
                chk("wrap_data", rd_data, 32'(8'h30 + n_rd));
            end
            tick();
            if (n_wr < 20) n_wr++;
            if (cyc >= 2) n_rd++;
            chk("wrap_count", bus.count, 32'(n_wr - n_rd));
        end
        bus.wr0_valid = 1'b0; bus.rd_ready = 1'b0;
        chk("wrap_empty", bus.empty, 1);

        // Write refused at full even with a same-cycle pop
        for (int i = 0; i < 8; i++) begin
            bus.wr0_valid = 1'b1; bus.wr0_data = 8'(8'h60 + i);
            tick();
        end
        chk("fp_full", bus.full, 1);
        bus.wr0_data = 8'h68; bus.rd_ready = 1'b1;
        #1;
        chk("fp_ready", bus.wr0_ready, 0);
        chk("fp_rd", rd_data, 32'h60);
        tick();
        chk("fp_count7", bus.count, 7);
        bus.rd_ready = 1'b0;
        #1;
        chk("fp_retry_ready", bus.wr0_ready, 1);
        tick();
        chk("fp_count8", bus.count, 8);
        chk("fp_full_again", bus.full, 1);
        bus.wr0_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.rd_ready = 1'b1;
            #1;
            chk("fp_drain", rd_data, 32'(8'h61 + i));
            tick();
        end
        bus.rd_ready = 1'b0;

        // Reset in the middle of a stream
        for (int i = 0; i < 5; i++) begin
            bus.wr0_valid = 1'b1; bus.wr0_data = 8'(8'h70 + i);
            tick();
        end
        bus.wr0_valid = 1'b0;
        chk("ms_count5", bus.count, 5);
        #2 rst = 1'b1;
        #1;
        chk("ms_rst_count", bus.count, 0);
        chk("ms_rst_empty", bus.empty, 1);
        tick();
        rst = 1'b0;
        tick();
        bus.wr0_valid = 1'b1; bus.wr0_data = 8'h55;
        tick();
        bus.wr0_valid = 1'b0;
        #1;
        chk("ms_rd_valid", bus.rd_valid, 1);
        chk("ms_rd_data", rd_data, 32'h55);
        chk("ms_count1", bus.count, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
